bf_ctrl_param: RTL and testbench

Parametrised next-generation control FSM for the brainfuck machine. It decodes 4-bit opcodes from program memory and drives the PC, data-pointer and data-memory strobes. Unlike the previous controller, it owns the bracket-depth counter and the +/- ALU, and it reports halt/error status. It sits between the program ROM/PC counter, the data RAM/DP counter, the switch input and the display output.

---
 rtl/bf_pkg.sv | 46 ++++
 rtl/bf_bracket_cnt.sv | 46 ++++
 rtl/bf_ctrl_param.sv | 232 +++++++++++++++++++++++
 tb/tb_bf_ctrl_param.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck control FSM: opcodes, error codes, state set.
// The STEP_WAIT state exists only when BF_STEP_EN is defined.
package bf_pkg;

    localparam logic [3:0] OP_LT   = 4'h0;
    localparam logic [3:0] OP_GT   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_JNZ  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_STOP = 4'hF;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OPCODE    = 2'd1;
    localparam logic [1:0] ERR_DEPTH     = 2'd2;
    localparam logic [1:0] ERR_UNMATCHED = 2'd3;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DP,
        S_RD,
        S_WR,
        S_ADV,
        S_TEST_O,
        S_SCAN_F,
        S_SCAN_FD,
        S_TEST_C,
        S_SCAN_B,
        S_SCAN_BD,
        S_OUT,
        S_OW_HI,
        S_OW_LO,
        S_IN_HI,
        S_IN_LO,
        S_HALT,
        S_ERROR
`ifdef BF_STEP_EN
        , S_STEP_WAIT
`endif
    } state_e;

endpackage

// File: rtl/bf_bracket_cnt.sv
// Bracket depth counter: clear, load-to-one, saturating increment, floor-at-zero decrement.
// sat_o flags the all-ones value so the controller can detect overflow before incrementing.
module bf_bracket_cnt #(
    parameter int unsigned BC_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            load1_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [BC_W-1:0] cnt_o,
    output logic            sat_o,
    output logic            one_o
);

    logic [BC_W-1:0] cnt_q, cnt_d;

    // Next count, priority clear > load > inc > dec
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = BC_W'(1);
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + BC_W'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - BC_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == '1);
    assign one_o = (cnt_q == BC_W'(1));

endmodule

// File: rtl/bf_ctrl_param.sv
// Brainfuck control FSM: decodes opcodes, drives PC/DP/RAM strobes, runs bracket scans,
// and reports halt/error status. Optional single-step gate via macro BF_STEP_EN.
module bf_ctrl_param
    import bf_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned BC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [3:0]        instr,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_done,
    input  logic              out_done,
`ifdef BF_STEP_EN
    input  logic              step,
`endif
    output logic              pc_en,
    output logic              pc_dir,
    output logic              dp_en,
    output logic              dp_dir,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] wdata,
    output logic              out_ld,
    output logic              in_req,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [BC_W-1:0]   depth
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [1:0] err_code_q, err_code_d;
    logic       cnt_clr, cnt_ld1, cnt_inc, cnt_dec, cnt_sat, cnt_one;

    bf_bracket_cnt #(.BC_W(BC_W)) u_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (cnt_clr),
        .load1_i (cnt_ld1),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .cnt_o   (depth),
        .sat_o   (cnt_sat),
        .one_o   (cnt_one)
    );

    // State, latched opcode and error code registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state, strobes and depth-counter control
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        err_code_d = err_code_q;
        cnt_clr    = 1'b0;
        cnt_ld1    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        pc_en      = 1'b0;
        pc_dir     = 1'b0;
        dp_en      = 1'b0;
        dp_dir     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        wdata      = '0;
        out_ld     = 1'b0;
        in_req     = 1'b0;
        case (state_q)
            S_IDLE:   if (go) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = instr;
                case (instr)
                    OP_LT, OP_GT:                        state_d = S_DP;
                    OP_INC, OP_DEC, OP_JZ, OP_JNZ, OP_OUT: state_d = S_RD;
                    OP_IN:                               state_d = S_IN_HI;
                    OP_STOP:                             state_d = S_HALT;
                    default: begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_OPCODE;
                    end
                endcase
            end
            S_DP: begin
                dp_en   = 1'b1;
                dp_dir  = (op_q == OP_LT);
                state_d = S_ADV;
            end
            // One read state serves every cell-reading opcode; op_q picks the follow-up
            S_RD: begin
                mem_rd = 1'b1;
                case (op_q)
                    OP_JZ:   state_d = S_TEST_O;
                    OP_JNZ:  state_d = S_TEST_C;
                    OP_OUT:  state_d = S_OUT;
                    default: state_d = S_WR;
                endcase
            end
            S_WR: begin
                mem_wr  = 1'b1;
                wdata   = (op_q == OP_DEC) ? dout - ONE : dout + ONE;
                state_d = S_ADV;
            end
            S_ADV: begin
                pc_en   = 1'b1;
`ifdef BF_STEP_EN
                state_d = S_STEP_WAIT;
`else
                state_d = S_FETCH;
`endif
            end
`ifdef BF_STEP_EN
            S_STEP_WAIT: if (step) state_d = S_FETCH;
`endif
            S_TEST_O: begin
                if (dout == '0) begin
                    cnt_ld1 = 1'b1;
                    state_d = S_SCAN_F;
                end else begin
                    state_d = S_ADV;
                end
            end
            S_SCAN_F: begin
                if (pc == '1) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_UNMATCHED;
                end else begin
                    pc_en   = 1'b1;
                    state_d = S_SCAN_FD;
                end
            end
            S_SCAN_FD: begin
                state_d = S_SCAN_F;
                if (instr == OP_JZ) begin
                    if (cnt_sat) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_DEPTH;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (instr == OP_JNZ) begin
                    if (cnt_one) begin
                        cnt_clr = 1'b1;
                        state_d = S_ADV;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_TEST_C: begin
                if (dout != '0) begin
                    cnt_ld1 = 1'b1;
                    state_d = S_SCAN_B;
                end else begin
                    state_d = S_ADV;
                end
            end
            S_SCAN_B: begin
                if (pc == '0) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_UNMATCHED;
                end else begin
                    pc_en   = 1'b1;
                    pc_dir  = 1'b1;
                    state_d = S_SCAN_BD;
                end
            end
            S_SCAN_BD: begin
                state_d = S_SCAN_B;
                if (instr == OP_JNZ) begin
                    if (cnt_sat) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_DEPTH;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (instr == OP_JZ) begin
                    if (cnt_one) begin
                        cnt_clr = 1'b1;
                        state_d = S_ADV;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_OUT: begin
                out_ld  = 1'b1;
                state_d = S_OW_HI;
            end
            S_OW_HI: if (out_done)  state_d = S_OW_LO;
            S_OW_LO: if (!out_done) state_d = S_ADV;
            S_IN_HI: begin
                in_req = 1'b1;
                if (in_done) begin
                    mem_wr  = 1'b1;
                    wdata   = in_data;
                    state_d = S_IN_LO;
                end
            end
            S_IN_LO: if (!in_done) state_d = S_ADV;
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
    assign halted   = (state_q == S_HALT);
    assign err      = (state_q == S_ERROR);
    assign err_code = err_code_q;

endmodule

// File: tb/tb_bf_ctrl_param.sv
`timescale 1ns/1ps
module tb_bf_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [3:0] instr;
    logic [7:0] pc, dout;
    logic [7:0] in_data = 8'h00;
    logic       in_done = 1'b0;
    logic       out_done;
    logic       pc_en, pc_dir, dp_en, dp_dir, mem_rd, mem_wr, out_ld, in_req, busy, halted, err;
    logic [7:0] wdata, depth;
    logic [1:0] err_code;
`ifdef BF_STEP_EN
    logic       step = 1'b1;
`endif

    // second instance with a 2-bit depth counter, fed a ROM of all '[' and a zero cell
    logic       go2 = 1'b0;
    logic [7:0] pc2;
    logic       pc_en2, pc_dir2, dp_en2, dp_dir2, mem_rd2, mem_wr2, out_ld2, in_req2, busy2, halted2, err2;
    logic [7:0] wdata2;
    logic [1:0] err_code2, depth2;

    always #5 clk = ~clk;

    bf_ctrl_param dut (
        .clk(clk), .reset(reset), .go(go), .instr(instr), .pc(pc), .dout(dout),
        .in_data(in_data), .in_done(in_done), .out_done(out_done),
`ifdef BF_STEP_EN
        .step(step),
`endif
        .pc_en(pc_en), .pc_dir(pc_dir), .dp_en(dp_en), .dp_dir(dp_dir),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wdata(wdata), .out_ld(out_ld), .in_req(in_req),
        .busy(busy), .halted(halted), .err(err), .err_code(err_code), .depth(depth)
    );

    bf_ctrl_param #(.DATA_W(8), .PC_W(8), .BC_W(2)) dut2 (
        .clk(clk), .reset(reset), .go(go2), .instr(4'h4), .pc(pc2), .dout(8'h00),
        .in_data(8'h00), .in_done(1'b0), .out_done(1'b0),
`ifdef BF_STEP_EN
        .step(step),
`endif
        .pc_en(pc_en2), .pc_dir(pc_dir2), .dp_en(dp_en2), .dp_dir(dp_dir2),
        .mem_rd(mem_rd2), .mem_wr(mem_wr2), .wdata(wdata2), .out_ld(out_ld2), .in_req(in_req2),
        .busy(busy2), .halted(halted2), .err(err2), .err_code(err_code2), .depth(depth2)
    );

    // ---------------- environment: ROM, PC/DP counters, RAM, display ----------------
    logic [3:0]  rom      [0:255];
    logic [7:0]  init_ram [0:255];
    logic [7:0]  ram      [0:255];
    logic [7:0]  outbuf   [0:63];
    logic [7:0]  dp, maxd;
    int unsigned out_n, wr_n, bwd_n, excl_n, ocnt;

    assign instr = rom[pc];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 8'd0; dp <= 8'd0; dout <= 8'd0; maxd <= 8'd0;
            out_n <= 0; wr_n <= 0; bwd_n <= 0; ocnt <= 0; out_done <= 1'b0;
            for (int i = 0; i < 256; i++) ram[i] <= init_ram[i];
        end else begin
            if (pc_en) pc <= pc_dir ? pc - 8'd1 : pc + 8'd1;
            if (pc_en && pc_dir) bwd_n <= bwd_n + 1;
            if (dp_en) dp <= dp_dir ? dp - 8'd1 : dp + 8'd1;
            if (mem_rd) dout <= ram[dp];
            if (mem_wr) begin
                ram[dp] <= wdata;
                wr_n    <= wr_n + 1;
            end
            if (depth > maxd) maxd <= depth;
            if (out_ld) begin
                if (out_n < 64) outbuf[out_n[5:0]] <= dout;
                out_n    <= out_n + 1;
                ocnt     <= 6;
                out_done <= 1'b0;
            end else if (ocnt > 0) begin
                ocnt     <= ocnt - 1;
                out_done <= (ocnt >= 3 && ocnt <= 5);
            end
        end
    end

    // sticky count of cycles with more than one exclusive strobe active
    always @(posedge clk or posedge reset) begin
        if (reset) excl_n <= excl_n;
        else if ($countones({pc_en, dp_en, mem_rd, mem_wr, out_ld}) > 1) excl_n <= excl_n + 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) pc2 <= 8'd0;
        else if (pc_en2) pc2 <= pc_dir2 ? pc2 - 8'd1 : pc2 + 8'd1;
    end

    // ---------------- checking ----------------
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference interpreter ----------------
    logic [7:0]  m_ram [0:255];
    logic [7:0]  m_out [0:63];
    int unsigned m_out_n, m_wr, m_pc, m_steps;

    task automatic model_run(output bit ok);
        int   match [0:255];
        int   stk [$];
        int   mdp;
        bit   done;
        for (int i = 0; i < 256; i++) begin
            match[i] = -1;
            m_ram[i] = init_ram[i];
        end
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 4'h4) stk.push_back(i);
            else if (rom[i] == 4'h5 && stk.size() > 0) begin
                match[i] = stk.pop_back();
                match[match[i]] = i;
            end
        end
        m_out_n = 0; m_wr = 0; m_pc = 0; m_steps = 0; mdp = 0; done = 0; ok = 0;
        while (!done && m_steps < 250) begin
            m_steps++;
            case (rom[m_pc])
                4'h0: mdp = (mdp + 255) % 256;
                4'h1: mdp = (mdp + 1) % 256;
                4'h2: begin m_ram[mdp] = m_ram[mdp] + 8'd1; m_wr++; end
                4'h3: begin m_ram[mdp] = m_ram[mdp] - 8'd1; m_wr++; end
                4'h4: if (m_ram[mdp] == 8'd0) m_pc = match[m_pc];
                4'h5: if (m_ram[mdp] != 8'd0) m_pc = match[m_pc];
                4'h6: begin
                    if (m_out_n < 64) m_out[m_out_n] = m_ram[mdp];
                    m_out_n++;
                end
                default: begin done = 1; ok = (rom[m_pc] == 4'hF); end
            endcase
            if (!done) m_pc++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_prog(input string s, input logic [3:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "<": rom[i] = 4'h0;  ">": rom[i] = 4'h1;
                "+": rom[i] = 4'h2;  "-": rom[i] = 4'h3;
                "[": rom[i] = 4'h4;  "]": rom[i] = 4'h5;
                ".": rom[i] = 4'h6;  ",": rom[i] = 4'h7;
                "x": rom[i] = 4'h9;
                default: rom[i] = 4'hF;
            endcase
        end
    endtask

    task automatic zero_ram();
        for (int i = 0; i < 256; i++) init_ram[i] = 8'h00;
    endtask

    task automatic start();
        @(negedge clk); reset = 1'b1; go = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic wait_stop(input int unsigned budget, output bit done);
        done = 0;
        for (int unsigned c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (halted || err) done = 1;
        end
    endtask

    task automatic gen_prog();
        int          open;
        int unsigned k, len, r;
        for (int i = 0; i < 256; i++) rom[i] = 4'hF;
        open = 0; k = 0;
        len = $urandom_range(4, 14);
        for (int unsigned i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2 && open < 3) begin
                rom[k] = 4'h4; open++;
            end else if (r < 4 && open > 0) begin
                rom[k] = 4'h5; open--;
            end else begin
                case ($urandom_range(0, 4))
                    0: rom[k] = 4'h0;
                    1: rom[k] = 4'h1;
                    2: rom[k] = 4'h2;
                    3: rom[k] = 4'h3;
                    default: rom[k] = 4'h6;
                endcase
            end
            k++;
        end
        while (open > 0) begin
            rom[k] = 4'h5; k++; open--;
        end
        for (int i = 0; i < 256; i++) init_ram[i] = 8'($urandom_range(0, 3));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          done, ok;
        int unsigned diffs;

        zero_ram();
        load_prog("#", 4'hF);
        repeat (2) @(negedge clk);
        check_eq("rst_status", {busy, halted, err, err_code, depth}, 32'h0);
        check_eq("rst_strobes", {pc_en, pc_dir, dp_en, dp_dir, mem_rd, mem_wr, out_ld, in_req, wdata}, 32'h0);
        check_eq("rst_dut2", {pc_en2, pc_dir2, dp_en2, dp_dir2, mem_rd2, mem_wr2, out_ld2, in_req2,
                              busy2, halted2, err2, err_code2, depth2, wdata2}, 32'h0);

        // "+++." then stop
        load_prog("+++.#", 4'hF); zero_ram(); start(); wait_stop(300, done);
        check_eq("t1_done", done, 1);
        check_eq("t1_out_n", out_n, 1);
        check_eq("t1_out", outbuf[0], 8'd3);
        check_eq("t1_cell", ram[0], 8'd3);
        check_eq("t1_pc", pc, 8'd4);
        check_eq("t1_stat", {busy, halted, err}, 3'b010);

        // forward scan over a nested loop
        load_prog("[+[-]].#", 4'hF); zero_ram(); start(); wait_stop(300, done);
        check_eq("t2_done", done, 1);
        check_eq("t2_maxd", maxd, 8'd2);
        check_eq("t2_depth", depth, 8'd0);
        check_eq("t2_wr_n", wr_n, 0);
        check_eq("t2_out", {out_n[7:0], outbuf[0]}, 16'h0100);
        check_eq("t2_pc", pc, 8'd7);

        // countdown loop: cell 2, one backward scan of two steps
        load_prog("++[-]#", 4'hF); zero_ram(); start(); wait_stop(300, done);
        check_eq("t3_done", done, 1);
        check_eq("t3_wr_n", wr_n, 4);
        check_eq("t3_cell", ram[0], 8'd0);
        check_eq("t3_bwd", bwd_n, 2);
        check_eq("t3_pc", pc, 8'd5);

        // input with in_done already high, held five cycles
        load_prog(",.#", 4'hF); zero_ram();
        in_data = 8'hA5; in_done = 1'b1;
        start();
        repeat (5) @(negedge clk);
        check_eq("t4_wr_once", wr_n, 1);
        check_eq("t4_cell", ram[0], 8'hA5);
        check_eq("t4_held_pc", pc, 8'd0);
        in_done = 1'b0;
        wait_stop(300, done);
        check_eq("t4_done", done, 1);
        check_eq("t4_out", outbuf[0], 8'hA5);
        check_eq("t4_wr_n", wr_n, 1);
        check_eq("t4_pc", pc, 8'd2);

        // '-' on zero wraps
        load_prog("-.#", 4'hF); zero_ram(); start(); wait_stop(300, done);
        check_eq("t5_done", done, 1);
        check_eq("t5_out", outbuf[0], 8'hFF);
        check_eq("t5_cell", ram[0], 8'hFF);

        // unmatched '[' runs off the top of program memory
        load_prog("[", 4'h2); zero_ram(); start(); wait_stop(1200, done);
        check_eq("t6_done", done, 1);
        check_eq("t6_err", {busy, halted, err, err_code}, 5'b00111);
        check_eq("t6_pc", pc, 8'hFF);
        @(negedge clk); go = 1'b1; @(negedge clk); go = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_sticky", {busy, err, err_code}, 4'b0111);

        // invalid opcode
        load_prog("x", 4'hF); zero_ram(); start(); wait_stop(100, done);
        check_eq("t7_done", done, 1);
        check_eq("t7_err", {err, err_code}, 3'b101);

        // reset in the middle of a forward scan
        load_prog("[", 4'h2); zero_ram(); start();
        repeat (30) @(negedge clk);
        check_eq("t8_midscan", {busy, depth}, 9'h101);
        reset = 1'b1; #1;
        check_eq("t8_abort", {busy, err, err_code, depth, pc_en, dp_en, mem_rd, mem_wr, out_ld, in_req}, 32'h0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t8_idle", {busy, halted, err, depth}, 32'h0);

        // depth overflow with a 2-bit counter
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        @(negedge clk); go2 = 1'b1; @(negedge clk); go2 = 1'b0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (err2) done = 1;
        end
        check_eq("t9_done", done, 1);
        check_eq("t9_err", {err2, err_code2, depth2}, 5'b11011);

        // random balanced programs against the interpreter
        for (int t = 0; t < 8; t++) begin
            ok = 0;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                gen_prog();
                model_run(ok);
            end
            if (ok) begin
                start();
                wait_stop(100 + m_steps * 60, done);
                check_eq($sformatf("r%0d_done", t), done, 1);
                check_eq($sformatf("r%0d_stat", t), {busy, halted, err}, 3'b010);
                check_eq($sformatf("r%0d_pc", t), pc, m_pc);
                check_eq($sformatf("r%0d_wr_n", t), wr_n, m_wr);
                check_eq($sformatf("r%0d_out_n", t), out_n, m_out_n);
                for (int i = 0; i < 64 && i < int'(m_out_n); i++)
                    check_eq($sformatf("r%0d_out%0d", t, i), outbuf[i], m_out[i]);
                diffs = 0;
                for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) diffs++;
                check_eq($sformatf("r%0d_ram_diffs", t), diffs, 0);
            end
        end

        check_eq("strobe_exclusive", excl_n, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
